// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table and constants shared by the seven-segment encoder and reader
package seg7_pkg;
  localparam int NDIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  typedef enum logic {IDLE, HOLD} out_state_e;
endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if: rebuilt-frame valid/ready bus
interface seg7_scan_reader_if;
  import seg7_pkg::*;
  logic [4*NDIGITS-1:0] frame_digits;
  logic [NDIGITS-1:0] frame_err;
  logic frame_valid;
  logic frame_ready;
  modport master(output frame_digits, frame_err, frame_valid, input frame_ready);
  modport slave(input frame_digits, frame_err, frame_valid, output frame_ready);
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: segment pattern to hex nibble, flagging non-glyph patterns
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);
  // search the shared glyph table; unmatched patterns give nibble 0 with err set
  always_comb begin
    nibble = 4'h0;
    err = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg == SEG_GLYPH[i]) begin
        nibble = 4'(i);
        err = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: rebuilds 4-digit frames from a scanned seven-segment bus
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic [NDIGITS-1:0]  an,
  seg7_scan_reader_if.master  frame,
  output logic                overrun
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  logic [6:0] s_seg, p_seg;
  logic [NDIGITS-1:0] s_an, p_an;
  logic [CW-1:0] cnt, cnt_nxt;
  logic captured, an_ok, same, capture, done, load;
  logic [3:0] nib;
  logic nib_err;
  logic [4*NDIGITS-1:0] slot_d, out_d;
  logic [NDIGITS-1:0] slot_e, out_e, seen;
  out_state_e state, state_nxt;

  seg7_pattern_decode u_dec (.seg(s_seg), .nibble(nib), .err(nib_err));

  assign an_ok = $onehot(~s_an);
  assign same = {s_an, s_seg} == {p_an, p_seg};
  assign cnt_nxt = !an_ok || !same ? '0 : cnt == CNT_MAX ? cnt : cnt + 1'b1;
  assign capture = an_ok && same && cnt_nxt == CNT_MAX && !captured;
  assign done = &seen;
  assign load = done && (state == IDLE || frame.frame_ready);

  // input registers plus the previous sample they are compared against
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg <= SEG_BLANK;
      s_an <= '0;
      p_seg <= SEG_BLANK;
      p_an <= '0;
    end else begin
      s_seg <= seg;
      s_an <= an;
      p_seg <= s_seg;
      p_an <= s_an;
    end
  end

  // stability counter; captured holds for the rest of an unchanged period
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      captured <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      captured <= an_ok && same && (captured || capture);
    end
  end

  // digit slots; seen restarts on the edge the frame moves to the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_d <= '0;
      slot_e <= '0;
      seen <= '0;
    end else begin
      for (int k = 0; k < NDIGITS; k++)
        if (capture && !s_an[k]) begin
          slot_d[4*k +: 4] <= nib;
          slot_e[k] <= nib_err;
        end
      seen <= (done ? '0 : seen) | (capture ? ~s_an : '0);
    end
  end

  // output handshake state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

  // next state: a frame arriving with the accept keeps us presenting
  always_comb state_nxt = state == IDLE ? (done ? HOLD : IDLE) : (frame.frame_ready && !done ? IDLE : HOLD);

  // presented frame and sticky overrun for frames dropped under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_d <= '0;
      out_e <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        out_d <= slot_d;
        out_e <= slot_e;
      end
      if (done && !load) overrun <= 1'b1;
    end
  end

  // outputs come only from registers
  always_comb begin
    frame.frame_valid = state == HOLD;
    frame.frame_digits = out_d;
    frame.frame_err = out_e;
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scenarios plus random scans against a run-length model
module tb_seg7_scan_reader;
  localparam int S = 4;
  localparam int H = S + 2;
  localparam logic [27:0] FR_A = {7'h47, 7'h7F, 7'h30, 7'h5B};
  localparam logic [27:0] FR_B = {7'h77, 7'h01, 7'h4F, 7'h33};
  logic clk = 1'b0;
  logic rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic overrun;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [15:0] m_sd = '0, m_od = '0;
  logic [3:0] m_se = '0, m_oe = '0, m_seen = '0, m_pan = '0;
  logic m_valid = 1'b0, m_ovr = 1'b0, m_pend = 1'b0, m_have = 1'b0;
  logic [10:0] m_last = '0;
  logic [6:0] m_pseg = '0;
  int m_run = 0;

  seg7_scan_reader_if fif ();
  seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .frame(fif), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] dec(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (g == glyph[i]) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  // one clock: drive at negedge, advance the model at the edge, return at next negedge
  task automatic step(input logic [6:0] sg, input logic [3:0] a, input logic rdy, input logic r);
    logic [4:0] dv;
    seg = sg;
    an = a;
    fif.frame_ready = rdy;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_od = '0; m_oe = '0; m_seen = '0; m_valid = 0; m_ovr = 0; m_pend = 0; m_have = 0; m_run = 0;
    end else begin
      if (&m_seen) begin
        if (!m_valid || rdy) begin
          m_od = m_sd; m_oe = m_se; m_valid = 1;
        end else m_ovr = 1;
        m_seen = '0;
      end else if (m_valid && rdy) m_valid = 0;
      if (m_pend) begin
        dv = dec(m_pseg);
        for (int k = 0; k < 4; k++)
          if (!m_pan[k]) begin
            m_sd[4*k +: 4] = dv[3:0]; m_se[k] = dv[4]; m_seen[k] = 1;
          end
      end
      m_pend = 0;
      m_run = (m_have && {a, sg} == m_last) ? m_run + 1 : 1;
      m_last = {a, sg};
      m_have = 1;
      if ($countones(~a) == 1 && m_run == S) begin
        m_pend = 1; m_pan = a; m_pseg = sg;
      end
    end
    @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] g, input int first, input int last, input logic rdy);
    for (int d = first; d <= last; d++)
      for (int j = 0; j < H; j++) step(g[7*d +: 7], ~4'(1 << d), rdy, 1'b0);
  endtask

  task automatic test_reset;
    step(7'h00, 4'hF, 1'b0, 1'b1);
    step(7'h00, 4'hF, 1'b0, 1'b1);
    n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", fif.frame_valid); end
    n_cmp++; if (fif.frame_digits !== 16'h0) begin n_bad++; $display("FAIL reset_digits: got %h want 0000", fif.frame_digits); end
    n_cmp++; if (fif.frame_err !== 4'h0) begin n_bad++; $display("FAIL reset_err: got %b want 0000", fif.frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_clean_scan;
    scan(FR_A, 0, 2, 1'b0);
    for (int j = 0; j < H; j++) begin
      step(7'h47, 4'b0111, 1'b0, 1'b0);
      if (j == S) begin
        n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL clean_early: got %b want 0", fif.frame_valid); end
      end
      if (j == S + 1) begin
        n_cmp++; if (fif.frame_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid: got %b want 1", fif.frame_valid); end
      end
    end
    n_cmp++; if (fif.frame_digits !== 16'hF815) begin n_bad++; $display("FAIL clean_digits: got %h want F815", fif.frame_digits); end
    n_cmp++; if (fif.frame_err !== 4'h0) begin n_bad++; $display("FAIL clean_err: got %b want 0000", fif.frame_err); end
    step(7'h00, 4'hF, 1'b1, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL clean_accept: got %b want 0", fif.frame_valid); end
  endtask

  task automatic test_glitch;
    scan(FR_A, 1, 3, 1'b0);
    for (int j = 0; j < S - 1; j++) step(7'h7E, 4'b1110, 1'b0, 1'b0);
    for (int j = 0; j < H; j++) step(7'h00, 4'hF, 1'b0, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_captured: got valid %b want 0", fif.frame_valid); end
    scan(FR_A, 0, 0, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b1) begin n_bad++; $display("FAIL glitch_valid: got %b want 1", fif.frame_valid); end
    n_cmp++; if (fif.frame_digits !== 16'hF815) begin n_bad++; $display("FAIL glitch_digits: got %h want F815", fif.frame_digits); end
    step(7'h00, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic test_illegal;
    scan(FR_B, 0, 3, 1'b0);
    n_cmp++; if (fif.frame_err !== 4'b0100) begin n_bad++; $display("FAIL illegal_err: got %b want 0100", fif.frame_err); end
    n_cmp++; if (fif.frame_digits !== 16'hA0E4) begin n_bad++; $display("FAIL illegal_digits: got %h want A0E4", fif.frame_digits); end
    step(7'h00, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    scan(FR_A, 0, 3, 1'b0);
    scan(FR_B, 0, 3, 1'b0);
    n_cmp++; if (fif.frame_digits !== 16'hF815) begin n_bad++; $display("FAIL bp_held: got %h want F815", fif.frame_digits); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    step(7'h00, 4'hF, 1'b1, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop: got %b want 0", fif.frame_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL bp_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back;
    step(7'h00, 4'hF, 1'b0, 1'b1);
    scan(FR_A, 0, 3, 1'b0);
    scan(FR_B, 0, 2, 1'b0);
    for (int j = 0; j < H; j++) step(7'h77, 4'b0111, j == S + 1, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", fif.frame_valid); end
    n_cmp++; if (fif.frame_digits !== 16'hA0E4) begin n_bad++; $display("FAIL b2b_digits: got %h want A0E4", fif.frame_digits); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    step(7'h00, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    scan(FR_A, 0, 1, 1'b0);
    step(7'h00, 4'hF, 1'b0, 1'b1);
    scan(FR_A, 2, 3, 1'b0);
    for (int j = 0; j < H; j++) step(7'h00, 4'hF, 1'b0, 1'b0);
    n_cmp++; if (fif.frame_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", fif.frame_valid); end
    n_cmp++; if ({fif.frame_digits, fif.frame_err, overrun} !== 21'h0) begin
      n_bad++; $display("FAIL mid_outputs: got %h/%b/%b want 0", fif.frame_digits, fif.frame_err, overrun);
    end
  endtask

  task automatic test_random;
    logic [6:0] sg;
    logic [3:0] a;
    int hold;
    step(7'h00, 4'hF, 1'b0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, 9) < 8 ? ~4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      sg = $urandom_range(0, 4) == 0 ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      hold = $urandom_range(1, S + 3);
      for (int j = 0; j < hold; j++) begin
        step(sg, a, $urandom_range(0, 2) == 0, $urandom_range(0, 999) == 0);
        n_cmp++;
        if ({fif.frame_valid, overrun, fif.frame_err, fif.frame_digits} !== {m_valid, m_ovr, m_oe, m_od}) begin
          n_bad++;
          $display("FAIL random[%0d]: got v%b o%b e%b d%h want v%b o%b e%b d%h", n, fif.frame_valid, overrun,
                   fif.frame_err, fif.frame_digits, m_valid, m_ovr, m_oe, m_od);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    seg = 7'h00;
    an = 4'hF;
    fif.frame_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_clean_scan;
    test_glitch;
    test_illegal;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
